// File: rtl/ddr_arb_pkg.sv
// Shared state/grant types and default widths for the DDR receive-side arbiter.
package ddr_arb_pkg;
  localparam int DEF_ADDR_W     = 25;
  localparam int DEF_DATA_W     = 256;
  localparam int BYTES_PER_WORD = 32;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } arb_state_e;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;
endpackage

// File: rtl/ddr_word_fifo.sv
// Synchronous word FIFO holding packed DDR write words; exposes head and occupancy.
module ddr_word_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/ddr_rx_arbiter.sv
// Packs received bytes into DDR words, queues them, and arbitrates DDR writes against read requests.
module ddr_rx_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        byte_in,
  input  logic              byte_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wr_limit,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_ack,
  output logic [DATA_W-1:0] rd_out_data,
  output logic              rd_out_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic              wr_busy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic              rd_busy,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              overflow,
  output logic [31:0]       words_written
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      HIGH_CNT  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Packer state
  logic [DATA_W-1:0]     pack_q, pack_d, push_data_q, push_data_d;
  logic [BYTE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  push_q, push_d, overflow_q, overflow_d;
  // FIFO interface
  logic                  fifo_push, fifo_pop;
  logic [DATA_W-1:0]     fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  // Arbiter state and registered outputs
  arb_state_e            state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d, rd_out_data_q, rd_out_data_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_ack_q, rd_ack_d;
  logic                  rd_out_valid_q, rd_out_valid_d;
  logic [31:0]           words_written_q, words_written_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pack_d      = pack_q;
    byte_cnt_d  = byte_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (byte_en) begin
      pack_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (byte_cnt_q == LAST_BYTE) begin
        push_d      = 1'b1;
        push_data_d = pack_d;
        pack_d      = '0;
      end
    end
    // A flush that coincides with the completing byte is absorbed by that push.
    if (flush && !push_d && (byte_cnt_d != '0)) begin
      push_d      = 1'b1;
      push_data_d = pack_d;
      pack_d      = '0;
      byte_cnt_d  = '0;
    end
    fifo_push  = push_q && (fifo_count != FULL_CNT);
    overflow_d = overflow_q || (push_q && (fifo_count == FULL_CNT));
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_q      <= '0;
      byte_cnt_q  <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      byte_cnt_q  <= byte_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  ddr_word_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifo_push),
    .push_data(push_data_q),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wr_ptr_d        = wr_ptr_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    wr_en_d         = 1'b0;
    rd_addr_d       = rd_addr_q;
    rd_en_d         = 1'b0;
    rd_ack_d        = 1'b0;
    rd_out_data_d   = rd_out_data_q;
    rd_out_valid_d  = 1'b0;
    words_written_d = words_written_q;
    fifo_pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Near-full FIFO forces a write; otherwise a tie alternates against the last grant.
        if ((fifo_count >= HIGH_CNT) ||
            ((fifo_count != '0) && (!rd_req || (last_grant_q == GRANT_READ)))) begin
          state_d      = ST_WR_ISSUE;
          last_grant_d = GRANT_WRITE;
        end else if (rd_req) begin
          state_d      = ST_RD_ISSUE;
          last_grant_d = GRANT_READ;
        end
      end
      ST_WR_ISSUE: begin
        if (!wr_busy) begin
          wr_en_d         = 1'b1;
          wr_addr_d       = wr_ptr_q;
          wr_data_d       = fifo_head;
          fifo_pop        = 1'b1;
          words_written_d = words_written_q + 32'd1;
          wr_ptr_d        = (wr_ptr_q == wr_limit) ? '0 : wr_ptr_q + 1'b1;
          state_d         = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (!wr_busy) state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        if (!rd_busy) begin
          rd_en_d   = 1'b1;
          rd_ack_d  = 1'b1;
          rd_addr_d = rd_req_addr;
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rd_data_valid) begin
          rd_out_data_d  = rd_data;
          rd_out_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= GRANT_WRITE;
      wr_ptr_q        <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      rd_en_q         <= 1'b0;
      rd_ack_q        <= 1'b0;
      rd_out_data_q   <= '0;
      rd_out_valid_q  <= 1'b0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wr_ptr_q        <= wr_ptr_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      wr_en_q         <= wr_en_d;
      rd_addr_q       <= rd_addr_d;
      rd_en_q         <= rd_en_d;
      rd_ack_q        <= rd_ack_d;
      rd_out_data_q   <= rd_out_data_d;
      rd_out_valid_q  <= rd_out_valid_d;
      words_written_q <= words_written_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_req_ack    = rd_ack_q;
  assign rd_out_data   = rd_out_data_q;
  assign rd_out_valid  = rd_out_valid_q;
  assign overflow      = overflow_q;
  assign words_written = words_written_q;
endmodule

// File: tb/tb_ddr_rx_arbiter.sv
// Directed bench for ddr_rx_arbiter: packing, flush, overflow, reads, arbitration, wrap and reset.
module tb_ddr_rx_arbiter;
  localparam int ADDR_W     = 25;
  localparam int DATA_W     = 256;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 10;
  localparam logic [DATA_W-1:0] RESP_DATA = 256'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rstn;
  logic [7:0]        byte_in;
  logic              byte_en, flush, rd_req, wr_busy, rd_busy, rd_data_valid;
  logic [ADDR_W-1:0] wr_limit, rd_req_addr, wr_addr, rd_addr;
  logic              rd_req_ack, rd_out_valid, wr_en, rd_en, overflow;
  logic [DATA_W-1:0] rd_out_data, wr_data, rd_data;
  logic [31:0]       words_written;

  always #5 clk = ~clk;

  ddr_rx_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .byte_in(byte_in), .byte_en(byte_en), .flush(flush),
    .wr_limit(wr_limit), .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_req_ack(rd_req_ack),
    .rd_out_data(rd_out_data), .rd_out_valid(rd_out_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .wr_busy(wr_busy), .rd_addr(rd_addr), .rd_en(rd_en), .rd_busy(rd_busy),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .overflow(overflow),
    .words_written(words_written)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int ack_cnt = 0, ov_cnt = 0, ov_cyc = 0, dv_cyc = 0, resp_dly = 0;
  logic [DATA_W-1:0] ov_data;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  string ev_s = "";

  always @(posedge clk) cyc++;

  // Monitor plus DDR read model; outputs are sampled on the falling edge.
  always @(negedge clk) begin
    rd_data_valid = 1'b0;
    if (resp_dly > 0) begin
      resp_dly--;
      if (resp_dly == 0) begin
        rd_data_valid = 1'b1;
        dv_cyc = cyc;
      end
    end
    if (rd_en) begin
      rd_addr_log.push_back(rd_addr);
      ev_s = {ev_s, "R"};
      resp_dly = RD_LAT;
    end
    if (wr_en) begin
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(wr_data);
      ev_s = {ev_s, "W"};
    end
    if (rd_req_ack) ack_cnt++;
    if (rd_out_valid) begin
      ov_cnt++;
      ov_cyc  = cyc;
      ov_data = rd_out_data;
    end
  end

  function automatic logic [DATA_W-1:0] word_pat(input int w);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = 8'(w * 32 + k);
    return v;
  endfunction

  // Advance n falling edges; the requester drops rd_req once it sees the ack.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rd_req_ack) rd_req = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_en = 1'b1;
    byte_in = b;
    step(1);
    byte_en = 1'b0;
  endtask

  task automatic send_word(input int w);
    for (int k = 0; k < 32; k++) send_byte(8'(w * 32 + k));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    byte_en = 1'b0; flush = 1'b0; rd_req = 1'b0; wr_busy = 1'b0; rd_busy = 1'b0;
    byte_in = '0; rd_req_addr = '0; wr_limit = '1;
    step(3);
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    rd_data = RESP_DATA;
    do_reset();
    tests_run++;
    if ({wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_req_ack} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cmd_outputs: wr_en=%b wr_addr=%0h rd_en=%b rd_addr=%0h ack=%b required all 0",
               wr_en, wr_addr, rd_en, rd_addr, rd_req_ack);
    end
    tests_run++;
    if ({rd_out_valid, rd_out_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rd_out: valid=%b data=%0h required 0", rd_out_valid, rd_out_data);
    end
    tests_run++;
    if ({overflow, words_written} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: overflow=%b words_written=%0d required 0", overflow, words_written);
    end
  endtask

  task automatic test_full_word();
    int b = wr_addr_log.size();
    logic [DATA_W-1:0] exp = '0;
    for (int k = 0; k < 32; k++) exp[8*k +: 8] = 8'(k);
    for (int k = 0; k < 32; k++) send_byte(8'(k));
    step(12);
    tests_run++;
    if (wr_addr_log.size() - b != 1) begin
      tests_failed++;
      $display("FAIL full_word_count: got %0d writes required 1", wr_addr_log.size() - b);
    end
    if (wr_addr_log.size() > b) begin
      tests_run++;
      if (wr_addr_log[b] !== 25'd0 || wr_data_log[b] !== exp) begin
        tests_failed++;
        $display("FAIL full_word_cmd: addr=%0h data=%h required addr=0 data=%h", wr_addr_log[b], wr_data_log[b], exp);
      end
    end
    tests_run++;
    if (words_written !== 32'd1) begin
      tests_failed++;
      $display("FAIL full_word_words_written: got %0d required 1", words_written);
    end
  endtask

  task automatic test_flush();
    int b = wr_addr_log.size();
    logic [DATA_W-1:0] exp = {216'd0, 40'hA5A4A3A2A1};
    for (int k = 1; k <= 5; k++) send_byte(8'(8'hA0 + k));
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(12);
    tests_run++;
    if (wr_addr_log.size() - b != 1) begin
      tests_failed++;
      $display("FAIL flush_count: got %0d writes required 1", wr_addr_log.size() - b);
    end
    if (wr_addr_log.size() > b) begin
      tests_run++;
      if (wr_addr_log[b] !== 25'd1 || wr_data_log[b] !== exp) begin
        tests_failed++;
        $display("FAIL flush_cmd: addr=%0h data=%h required addr=1 data=%h", wr_addr_log[b], wr_data_log[b], exp);
      end
    end
  endtask

  task automatic test_flush_edges();
    int b = wr_addr_log.size();
    logic [DATA_W-1:0] exp = '0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(10);
    tests_run++;
    if (wr_addr_log.size() != b) begin
      tests_failed++;
      $display("FAIL flush_empty: got %0d writes required 0", wr_addr_log.size() - b);
    end
    for (int k = 0; k < 32; k++) exp[8*k +: 8] = 8'(8'h40 + k);
    for (int k = 0; k < 31; k++) send_byte(8'(8'h40 + k));
    flush = 1'b1;
    send_byte(8'h5F);
    flush = 1'b0;
    step(20);
    tests_run++;
    if (wr_addr_log.size() - b != 1) begin
      tests_failed++;
      $display("FAIL flush_with_last_byte_count: got %0d writes required 1", wr_addr_log.size() - b);
    end
    if (wr_addr_log.size() > b) begin
      tests_run++;
      if (wr_addr_log[b] !== 25'd2 || wr_data_log[b] !== exp) begin
        tests_failed++;
        $display("FAIL flush_with_last_byte_cmd: addr=%0h data=%h required addr=2 data=%h",
                 wr_addr_log[b], wr_data_log[b], exp);
      end
    end
  endtask

  task automatic test_overflow();
    int b;
    do_reset();
    b = wr_addr_log.size();
    wr_busy = 1'b1;
    for (int w = 1; w <= 6; w++) send_word(w);
    step(4);
    tests_run++;
    if (overflow !== 1'b1 || wr_addr_log.size() != b) begin
      tests_failed++;
      $display("FAIL overflow_while_busy: overflow=%b writes=%0d required overflow=1 writes=0",
               overflow, wr_addr_log.size() - b);
    end
    wr_busy = 1'b0;
    step(40);
    tests_run++;
    if (wr_addr_log.size() - b != 4) begin
      tests_failed++;
      $display("FAIL overflow_drain_count: got %0d writes required 4", wr_addr_log.size() - b);
    end
    if (wr_addr_log.size() - b == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (wr_addr_log[b+i] !== ADDR_W'(i) || wr_data_log[b+i] !== word_pat(i + 1)) begin
          tests_failed++;
          $display("FAIL overflow_drain_word%0d: addr=%0h data=%h required addr=%0h data=%h",
                   i, wr_addr_log[b+i], wr_data_log[b+i], i, word_pat(i + 1));
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || words_written !== 32'd4) begin
      tests_failed++;
      $display("FAIL overflow_sticky: overflow=%b words_written=%0d required 1 and 4", overflow, words_written);
    end
  endtask

  task automatic test_read();
    int rb = rd_addr_log.size();
    int ab = ack_cnt;
    int ob = ov_cnt;
    rd_req_addr = 25'h00123;
    rd_req = 1'b1;
    step(30);
    tests_run++;
    if (rd_addr_log.size() - rb != 1) begin
      tests_failed++;
      $display("FAIL read_count: got %0d rd_en required 1", rd_addr_log.size() - rb);
    end
    if (rd_addr_log.size() > rb) begin
      tests_run++;
      if (rd_addr_log[rb] !== 25'h00123) begin
        tests_failed++;
        $display("FAIL read_addr: got %0h required 123", rd_addr_log[rb]);
      end
    end
    tests_run++;
    if (ack_cnt - ab != 1 || rd_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_ack: got %0d ack cycles required 1", ack_cnt - ab);
    end
    tests_run++;
    if (ov_cnt - ob != 1) begin
      tests_failed++;
      $display("FAIL read_out_valid_count: got %0d cycles required 1", ov_cnt - ob);
    end
    tests_run++;
    if (ov_cyc != dv_cyc + 1 || ov_data !== RESP_DATA) begin
      tests_failed++;
      $display("FAIL read_return: out_valid cycle %0d data %0h required cycle %0d data %0h",
               ov_cyc, ov_data, dv_cyc + 1, RESP_DATA);
    end
  endtask

  task automatic test_reset_mid();
    int rb = rd_addr_log.size();
    int ab, ob;
    rd_req_addr = 25'h000AB;
    rd_req = 1'b1;
    step(5);
    tests_run++;
    if (rd_addr_log.size() - rb != 1) begin
      tests_failed++;
      $display("FAIL reset_mid_setup: got %0d rd_en required 1", rd_addr_log.size() - rb);
    end
    rstn = 1'b0;
    step(1);
    tests_run++;
    if ({rd_out_data, rd_out_valid, rd_en, rd_req_ack, wr_en, overflow, words_written} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: rd_out_data=%0h overflow=%b words_written=%0d required 0",
               rd_out_data, overflow, words_written);
    end
    rstn = 1'b1;
    rb = rd_addr_log.size();
    ab = ack_cnt;
    ob = ov_cnt;
    step(15);
    tests_run++;
    if (ov_cnt != ob || rd_addr_log.size() != rb || ack_cnt != ab) begin
      tests_failed++;
      $display("FAIL reset_mid_no_pulse: out_valid=%0d rd_en=%0d ack=%0d required 0 0 0",
               ov_cnt - ob, rd_addr_log.size() - rb, ack_cnt - ab);
    end
  endtask

  task automatic test_arb_tie();
    int eb;
    string ev;
    do_reset();
    eb = ev_s.len();
    byte_en = 1'b1; byte_in = 8'h77; flush = 1'b1;
    step(1);
    byte_en = 1'b0; flush = 1'b0;
    step(1);
    rd_req_addr = 25'h00456;
    rd_req = 1'b1;
    step(40);
    ev = ev_s.substr(eb, ev_s.len() - 1);
    tests_run++;
    if (ev != "RW") begin
      tests_failed++;
      $display("FAIL arb_tie_order: got '%s' required 'RW'", ev);
    end
  endtask

  task automatic test_arb_threshold();
    int eb;
    string ev;
    do_reset();
    eb = ev_s.len();
    wr_busy = 1'b1;
    for (int w = 1; w <= 4; w++) send_word(w);
    rd_req_addr = 25'h00789;
    rd_req = 1'b1;
    step(2);
    wr_busy = 1'b0;
    step(80);
    ev = ev_s.substr(eb, ev_s.len() - 1);
    tests_run++;
    if (ev != "WWRWW") begin
      tests_failed++;
      $display("FAIL arb_threshold_order: got '%s' required 'WWRWW'", ev);
    end
  endtask

  task automatic test_wrap();
    int b;
    logic [ADDR_W-1:0] exp_addr [4];
    exp_addr = '{25'd0, 25'd1, 25'd2, 25'd0};
    do_reset();
    b = wr_addr_log.size();
    wr_limit = 25'd2;
    for (int i = 0; i < 4; i++) begin
      byte_en = 1'b1; byte_in = 8'(8'h30 + i); flush = 1'b1;
      step(1);
      byte_en = 1'b0; flush = 1'b0;
      step(9);
    end
    step(10);
    tests_run++;
    if (wr_addr_log.size() - b != 4) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d writes required 4", wr_addr_log.size() - b);
    end
    if (wr_addr_log.size() - b == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (wr_addr_log[b+i] !== exp_addr[i] || wr_data_log[b+i] !== DATA_W'(8'h30 + i)) begin
          tests_failed++;
          $display("FAIL wrap_word%0d: addr=%0h data=%0h required addr=%0h data=%0h",
                   i, wr_addr_log[b+i], wr_data_log[b+i], exp_addr[i], 8'h30 + i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_flush_edges();
    test_overflow();
    test_read();
    test_reset_mid();
    test_arb_tie();
    test_arb_threshold();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
